// File: rtl/zybo_switches_axil_arbiter.sv
// Two-requester AXI4-Lite master arbiter sharing the Zybo_Switches slave port.
// Optional build macro: ZYBO_SW_ARB_FIXED_PRIORITY_EN (requester 0 always wins ties).
module zybo_switches_axil_arbiter #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic [1:0]                         REQ_VALID,
    output logic [1:0]                         REQ_READY,
    input  logic [1:0]                         REQ_WRITE,
    input  logic [2*C_M_AXI_ADDR_WIDTH-1:0]    REQ_ADDR,
    input  logic [2*C_M_AXI_DATA_WIDTH-1:0]    REQ_WDATA,
    output logic [1:0]                         RSP_VALID,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      RSP_RDATA,
    output logic [1:0]                         RSP_RESP,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
    output logic [2:0]                         M_AXI_AWPROT,
    output logic                               M_AXI_AWVALID,
    input  logic                               M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
    output logic                               M_AXI_WVALID,
    input  logic                               M_AXI_WREADY,
    input  logic [1:0]                         M_AXI_BRESP,
    input  logic                               M_AXI_BVALID,
    output logic                               M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [2:0]                         M_AXI_ARPROT,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA
    } state_t;

    state_t          state;
    logic            owner;
    logic            grant;
    logic            accept;
    logic            sel_write;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            aw_done;
    logic            w_done;

`ifndef ZYBO_SW_ARB_FIXED_PRIORITY_EN
    logic            last_grant;
`endif

    assign M_AXI_WSTRB  = {SW{1'b1}};
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    // Grant selection: on a tie the requester not served last wins
    always_comb begin
`ifdef ZYBO_SW_ARB_FIXED_PRIORITY_EN
        grant = ~REQ_VALID[0];
`else
        if (&REQ_VALID) begin
            grant = ~last_grant;
        end else begin
            grant = REQ_VALID[1];
        end
`endif
    end

    assign accept    = ARESETN && (state == ST_IDLE) && (|REQ_VALID);
    assign REQ_READY = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

    assign sel_write = grant ? REQ_WRITE[1] : REQ_WRITE[0];
    assign sel_addr  = grant ? REQ_ADDR[2*AW-1:AW] : REQ_ADDR[AW-1:0];
    assign sel_wdata = grant ? REQ_WDATA[2*DW-1:DW] : REQ_WDATA[DW-1:0];

    // A channel is finished once its VALID has dropped or is handshaking now
    assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_done  = !M_AXI_WVALID || M_AXI_WREADY;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= ST_IDLE;
            owner         <= 1'b0;
`ifndef ZYBO_SW_ARB_FIXED_PRIORITY_EN
            last_grant    <= 1'b1;
`endif
            RSP_VALID     <= 2'b00;
            RSP_RDATA     <= '0;
            RSP_RESP      <= 2'b00;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            RSP_VALID <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner <= grant;
`ifndef ZYBO_SW_ARB_FIXED_PRIORITY_EN
                        last_grant <= grant;
`endif
                        if (sel_write) begin
                            M_AXI_AWADDR  <= sel_addr;
                            M_AXI_WDATA   <= sel_wdata;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= ST_WR_ADDR_DATA;
                        end else begin
                            M_AXI_ARADDR  <= sel_addr;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_ADDR_DATA: begin
                    if (M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                    end
                    if (M_AXI_WREADY) begin
                        M_AXI_WVALID <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY     <= 1'b0;
                        RSP_VALID[owner] <= 1'b1;
                        RSP_RDATA        <= '0;
                        RSP_RESP         <= M_AXI_BRESP;
                        state            <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY     <= 1'b0;
                        RSP_VALID[owner] <= 1'b1;
                        RSP_RDATA        <= M_AXI_RDATA;
                        RSP_RESP         <= M_AXI_RRESP;
                        state            <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zybo_switches_axil_arbiter.sv
// Self-checking bench for zybo_switches_axil_arbiter with a latency-configurable AXI4-Lite slave.
module tb_zybo_switches_axil_arbiter;

    logic        ACLK;
    logic        ARESETN;
    logic [1:0]  REQ_VALID, REQ_READY, REQ_WRITE;
    logic [7:0]  REQ_ADDR;
    logic [63:0] REQ_WDATA;
    logic [1:0]  RSP_VALID, RSP_RESP;
    logic [31:0] RSP_RDATA;
    logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    zybo_switches_axil_arbiter #(.C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    // Slave model configuration (set by the test sequences)
    int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic        force_rd = 1'b0;
    logic [31:0] force_val = 32'h0;

    int          aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
    logic        aw_got, w_got, ar_got;
    logic [3:0]  s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    logic [31:0] smem [4];

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= aw_lat);
    assign M_AXI_WREADY  = M_AXI_WVALID && (w_wait >= w_lat);
    assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_wait >= ar_lat);

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0;
            M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
            M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
            for (int k = 0; k < 4; k++) smem[k] <= '0;
        end else begin
            aw_wait <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_wait + 1 : 0;
            w_wait  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_wait + 1 : 0;
            ar_wait <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_wait + 1 : 0;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_got <= 1'b1; s_awaddr <= M_AXI_AWADDR; end
            if (M_AXI_WVALID && M_AXI_WREADY) begin w_got <= 1'b1; s_wdata <= M_AXI_WDATA; end
            if (aw_got && w_got && !M_AXI_BVALID) begin
                if (b_cnt >= b_lat) begin
                    M_AXI_BVALID <= 1'b1;
                    M_AXI_BRESP  <= cfg_bresp;
                    smem[s_awaddr[3:2]] <= s_wdata;
                    b_cnt <= 0;
                end else b_cnt <= b_cnt + 1;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                M_AXI_BVALID <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_got <= 1'b1; s_araddr <= M_AXI_ARADDR; end
            if (ar_got && !M_AXI_RVALID) begin
                if (r_cnt >= r_lat) begin
                    M_AXI_RVALID <= 1'b1;
                    M_AXI_RRESP  <= cfg_rresp;
                    M_AXI_RDATA  <= force_rd ? force_val : smem[s_araddr[3:2]];
                    r_cnt <= 0;
                end else r_cnt <= r_cnt + 1;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                M_AXI_RVALID <= 1'b0; ar_got <= 1'b0;
            end
        end
    end

    // Protocol monitor counters, sampled mid-cycle
    int awv_cycles = 0, wv_cycles = 0, aw_hs = 0, w_hs = 0;
    int rsp_pulses = 0, both_ready = 0, bready_early = 0;

    always @(negedge ACLK) begin
        if (M_AXI_AWVALID) awv_cycles++;
        if (M_AXI_WVALID) wv_cycles++;
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_hs++;
        if (M_AXI_WVALID && M_AXI_WREADY) w_hs++;
        if (RSP_VALID != 2'b00) rsp_pulses++;
        if (REQ_READY == 2'b11) both_ready++;
        if (M_AXI_BREADY && !(aw_got && w_got)) bready_early++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input logic i);
        return i ? 2'b10 : 2'b01;
    endfunction

    // Arbitration rule expressed from the requester's point of view
    function automatic logic pick(input logic [1:0] v, input logic last);
`ifdef ZYBO_SW_ARB_FIXED_PRIORITY_EN
        return v[0] ? 1'b0 : 1'b1;
`else
        if (v == 2'b11) return ~last;
        return v[1];
`endif
    endfunction

    task automatic apply_reset();
        ARESETN   = 1'b0;
        REQ_VALID = 2'b00;
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
    endtask

    task automatic drive_cmd(input logic r, input logic wr, input logic [3:0] a, input logic [31:0] d);
        REQ_VALID = oh(r);
        REQ_WRITE = {wr, wr};
        REQ_ADDR  = {a, a};
        REQ_WDATA = {d, d};
    endtask

    // Issue one command, check launch timing, and return the response it got
    task automatic do_cmd(input logic r, input logic wr, input logic [3:0] a, input logic [31:0] d,
                          output logic [1:0] rv, output logic [31:0] rd, output logic [1:0] rr);
        bit got;
        rv = 2'b00; rd = '0; rr = 2'b00;
        @(posedge ACLK); #1;
        drive_cmd(r, wr, a, d);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge ACLK);
            if (REQ_READY[r]) got = 1;
        end
        if (!got) begin
            chk("accept_timeout", 32'(REQ_READY), 32'(oh(r)));
            REQ_VALID = 2'b00;
            return;
        end
        chk("ready_onehot", 32'(REQ_READY), 32'(oh(r)));
        @(posedge ACLK); #1;
        REQ_VALID = 2'b00;
        @(negedge ACLK);
        if (wr) begin
            chk("launch_awvalid", 32'({M_AXI_AWVALID, M_AXI_WVALID}), 32'h3);
            chk("launch_awaddr", 32'(M_AXI_AWADDR), 32'(a));
            chk("launch_wdata", M_AXI_WDATA, d);
            if (aw_lat == 0 && w_lat == 0)
                chk("launch_aw_w_hs", 32'({M_AXI_AWREADY, M_AXI_WREADY}), 32'h3);
        end else begin
            chk("launch_arvalid", 32'(M_AXI_ARVALID), 32'h1);
            chk("launch_araddr", 32'(M_AXI_ARADDR), 32'(a));
            if (ar_lat == 0) chk("launch_ar_hs", 32'(M_AXI_ARREADY), 32'h1);
        end
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge ACLK);
            if (RSP_VALID != 2'b00) begin
                got = 1; rv = RSP_VALID; rd = RSP_RDATA; rr = RSP_RESP;
            end
        end
        if (!got) begin
            chk("rsp_timeout", 32'(RSP_VALID), 32'(oh(r)));
            return;
        end
        @(negedge ACLK);
        chk("rsp_single_pulse", 32'(RSP_VALID), 32'h0);
    endtask

    typedef struct {
        logic        req;
        logic        write;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  slv_resp;
        logic        force_rd;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[8];

    logic [1:0]  rv, rr;
    logic [31:0] rd;
    int          order[4];
    int          exp_order[4];
    int          n_acc;

    // Random-phase model state
    logic [1:0]  vld;
    logic        cw [2];
    logic [3:0]  ca [2];
    logic [31:0] cd [2];
    logic [31:0] ref_mem [4];
    logic        busy, last, cur_owner, acc, g;
    logic [3:0]  cur_addr;
    logic [31:0] cur_data, cur_exp_rdata;
    logic [1:0]  exp_resp_q, exp_rdy;
    int          n_done;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 4'h4, 32'h0000_0005, 2'b00, 1'b0, 32'h0, 2'b00};
        vecs[1] = '{1'b0, 1'b0, 4'h4, 32'h0, 2'b00, 1'b0, 32'h0000_0005, 2'b00};
        vecs[2] = '{1'b1, 1'b1, 4'h8, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 2'b10};
        vecs[3] = '{1'b1, 1'b0, 4'h8, 32'h0, 2'b00, 1'b0, 32'hDEAD_BEEF, 2'b00};
        vecs[4] = '{1'b1, 1'b0, 4'hC, 32'h0, 2'b10, 1'b1, 32'hA5A5_A5A5, 2'b10};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h0, 2'b11, 1'b0, 32'h0, 2'b11};
        vecs[6] = '{1'b0, 1'b1, 4'hC, 32'h1234_5678, 2'b00, 1'b0, 32'h0, 2'b00};
        vecs[7] = '{1'b1, 1'b0, 4'hC, 32'h0, 2'b00, 1'b0, 32'h1234_5678, 2'b00};

        ARESETN = 1'b0;
        REQ_VALID = 2'b01; REQ_WRITE = 2'b00; REQ_ADDR = '0; REQ_WDATA = '0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_req_ready", 32'(REQ_READY), 32'h0);
        chk("rst_rsp", 32'({RSP_VALID, RSP_RESP}), 32'h0);
        chk("rst_rsp_rdata", RSP_RDATA, 32'h0);
        chk("rst_handshakes", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'h0);
        chk("rst_addr_data", 32'({M_AXI_AWADDR, M_AXI_ARADDR}) | M_AXI_WDATA, 32'h0);
        chk("fixed_fields", 32'({M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT}), 32'hF00 >> 2);
        REQ_VALID = 2'b00;
        @(posedge ACLK); #1 ARESETN = 1'b1;

        // Directed command table, zero-wait slave
        for (int i = 0; i < 8; i++) begin
            cfg_bresp = vecs[i].slv_resp;
            cfg_rresp = vecs[i].slv_resp;
            force_rd  = vecs[i].force_rd;
            force_val = 32'hA5A5_A5A5;
            do_cmd(vecs[i].req, vecs[i].write, vecs[i].addr, vecs[i].wdata, rv, rd, rr);
            chk($sformatf("vec%0d_rsp_valid", i), 32'(rv), 32'(oh(vecs[i].req)));
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_resp", i), 32'(rr), 32'(vecs[i].exp_resp));
        end
        force_rd = 1'b0; cfg_bresp = 2'b00; cfg_rresp = 2'b00;

        // Tie arbitration with both requesters held valid
        apply_reset();
`ifdef ZYBO_SW_ARB_FIXED_PRIORITY_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        both_ready = 0;
        @(posedge ACLK); #1;
        REQ_VALID = 2'b11; REQ_WRITE = 2'b00; REQ_ADDR = 8'h40; REQ_WDATA = '0;
        n_acc = 0;
        for (int c = 0; c < 100 && n_acc < 4; c++) begin
            @(negedge ACLK);
            if (REQ_READY != 2'b00) begin
                order[n_acc] = REQ_READY[1] ? 1 : 0;
                n_acc++;
            end
        end
        @(posedge ACLK); #1 REQ_VALID = 2'b00;
        repeat (10) @(posedge ACLK);
        chk("tie_accept_count", 32'(n_acc), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("tie_grant%0d", i), 32'(order[i]), 32'(exp_order[i]));
        chk("tie_both_ready", 32'(both_ready), 32'd0);

        // Split write handshakes: AW delayed three cycles, W immediate
        aw_lat = 3; w_lat = 0;
        awv_cycles = 0; wv_cycles = 0; aw_hs = 0; w_hs = 0; bready_early = 0;
        do_cmd(1'b0, 1'b1, 4'h8, 32'hCAFE_0001, rv, rd, rr);
        chk("split_awvalid_cycles", 32'(awv_cycles), 32'd4);
        chk("split_wvalid_cycles", 32'(wv_cycles), 32'd1);
        chk("split_hs_count", 32'(aw_hs * 16 + w_hs), 32'h11);
        chk("split_bready_early", 32'(bready_early), 32'd0);
        chk("split_rsp_valid", 32'(rv), 32'h1);
        aw_lat = 0;

        // Reset while waiting in the read data phase
        r_lat = 6;
        @(posedge ACLK); #1;
        drive_cmd(1'b1, 1'b0, 4'h8, 32'h0);
        n_acc = 0;
        for (int c = 0; c < 50 && n_acc == 0; c++) begin
            @(negedge ACLK);
            if (REQ_READY[1]) n_acc = 1;
        end
        @(posedge ACLK); #1 REQ_VALID = 2'b00;
        n_acc = 0;
        for (int c = 0; c < 50 && n_acc == 0; c++) begin
            @(negedge ACLK);
            if (M_AXI_RREADY) n_acc = 1;
        end
        chk("mid_reset_reached_rdata", 32'(n_acc), 32'd1);
        rsp_pulses = 0;
        ARESETN = 1'b0;
        REQ_VALID = 2'b01;
        @(negedge ACLK);
        chk("mid_reset_req_ready", 32'(REQ_READY), 32'h0);
        chk("mid_reset_handshakes", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'h0);
        chk("mid_reset_rsp", 32'({RSP_VALID, RSP_RESP}), 32'h0);
        chk("mid_reset_rdata", RSP_RDATA, 32'h0);
        chk("mid_reset_addr_data", 32'({M_AXI_AWADDR, M_AXI_ARADDR}) | M_AXI_WDATA, 32'h0);
        @(negedge ACLK);
        REQ_VALID = 2'b00;
        @(posedge ACLK); #1 ARESETN = 1'b1;
        r_lat = 0;
        repeat (10) @(posedge ACLK);
        chk("mid_reset_no_rsp", 32'(rsp_pulses), 32'd0);
        do_cmd(1'b0, 1'b0, 4'h8, 32'h0, rv, rd, rr);
        chk("post_reset_rsp_valid", 32'(rv), 32'h1);
        chk("post_reset_rdata", rd, 32'h0);

        // Randomized traffic against the behavioural model
        apply_reset();
        for (int k = 0; k < 4; k++) ref_mem[k] = '0;
        busy = 0; last = 1'b1; vld = 2'b00; n_done = 0;
        cur_owner = 0; cur_addr = '0; cur_data = '0; cur_exp_rdata = '0; exp_resp_q = 2'b00;
        for (int i = 0; i < 2; i++) begin cw[i] = 0; ca[i] = '0; cd[i] = '0; end
        g = 0;
        for (int cyc = 0; cyc < 1700; cyc++) begin
            @(negedge ACLK);
            if (M_AXI_AWVALID && M_AXI_AWREADY) chk("rnd_awaddr", 32'(M_AXI_AWADDR), 32'(cur_addr));
            if (M_AXI_WVALID && M_AXI_WREADY) chk("rnd_wdata", M_AXI_WDATA, cur_data);
            if (M_AXI_ARVALID && M_AXI_ARREADY) chk("rnd_araddr", 32'(M_AXI_ARADDR), 32'(cur_addr));
            if (RSP_VALID != 2'b00) begin
                chk("rnd_rsp_valid", 32'(RSP_VALID), busy ? 32'(oh(cur_owner)) : 32'h0);
                chk("rnd_rsp_rdata", RSP_RDATA, cur_exp_rdata);
                chk("rnd_rsp_resp", 32'(RSP_RESP), 32'(exp_resp_q));
                busy = 0;
                n_done++;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) exp_resp_q = M_AXI_BRESP;
            if (M_AXI_RVALID && M_AXI_RREADY) exp_resp_q = M_AXI_RRESP;
            exp_rdy = 2'b00;
            if (!busy && vld != 2'b00) begin
                g = pick(vld, last);
                exp_rdy = oh(g);
            end
            chk("rnd_req_ready", 32'(REQ_READY), 32'(exp_rdy));
            acc = (exp_rdy != 2'b00);
            if (acc) begin
                busy = 1; cur_owner = g; last = g;
                cur_addr = ca[g]; cur_data = cd[g];
                cur_exp_rdata = cw[g] ? 32'h0 : ref_mem[ca[g][3:2]];
                if (cw[g]) ref_mem[ca[g][3:2]] = cd[g];
            end
            @(posedge ACLK); #1;
            aw_lat = $urandom_range(0, 2); w_lat = $urandom_range(0, 2); b_lat = $urandom_range(0, 2);
            ar_lat = $urandom_range(0, 2); r_lat = $urandom_range(0, 2);
            cfg_bresp = 2'($urandom); cfg_rresp = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                if ((acc && g == 1'(i)) || !vld[i]) begin
                    vld[i] = (cyc < 1500) ? 1'($urandom_range(0, 1)) : 1'b0;
                    cw[i]  = 1'($urandom);
                    ca[i]  = {2'($urandom_range(0, 3)), 2'b00};
                    cd[i]  = $urandom;
                end
            end
            REQ_VALID = vld;
            REQ_WRITE = {cw[1], cw[0]};
            REQ_ADDR  = {ca[1], ca[0]};
            REQ_WDATA = {cd[1], cd[0]};
        end
        chk("rnd_drained", 32'(busy), 32'h0);
        chk("rnd_enough_cmds", 32'(n_done > 50), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
